// File: rtl/aluout_sequencer_pkg.sv
// Shared encodings for the ALUOut write sequencer: op classes, shifter commands and FSM states.
// The main control unit and the ALUOut source mux use the same constants.
package aluout_sequencer_pkg;

    localparam int unsigned DEF_SEL_W   = 3;
    localparam int unsigned DEF_SHAMT_W = 5;
    localparam int unsigned OP_W        = 3;
    localparam int unsigned SCTL_W      = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ALU_AUX = 3'd0,
        OP_ALU     = 3'd1,
        OP_SHIFT   = 3'd2,
        OP_PASS_A  = 3'd3,
        OP_SLT     = 3'd4
    } op_class_e;

    typedef enum logic [SCTL_W-1:0] {
        SC_NOP  = 3'd0,
        SC_LOAD = 3'd1,
        SC_SLL  = 3'd2,
        SC_SRL  = 3'd3,
        SC_SRA  = 3'd4,
        SC_ROR  = 3'd5,
        SC_ROL  = 3'd6
    } shift_ctrl_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_SH_LOAD = 3'd2,
        ST_SH_EXEC = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Classes that write ALUOut directly without the shifter.
    function automatic logic is_alu_class(input logic [OP_W-1:0] c);
        return (c == OP_ALU_AUX) || (c == OP_ALU) || (c == OP_PASS_A) || (c == OP_SLT);
    endfunction

    function automatic logic is_shift_type(input logic [SCTL_W-1:0] t);
        return (t >= SC_SLL) && (t <= SC_ROL);
    endfunction

endpackage

// File: rtl/aluout_exec_counter.sv
// Down-counter that times the shifter's busy cycles per shift command.
// Loads EXEC_CYCLES-1, decrements on request and flags zero.
module aluout_exec_counter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int unsigned CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(EXEC_CYCLES - 1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/aluout_sequencer.sv
// Multicycle sequencer for ALUOut writes: one write per R-type/immediate op,
// routing shifts through the shifter load/exec steps first.
module aluout_sequencer
    import aluout_sequencer_pkg::*;
#(
    parameter int unsigned SEL_W       = DEF_SEL_W,
    parameter int unsigned SHAMT_W     = DEF_SHAMT_W,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [OP_W-1:0]    op_class,
    input  logic [SCTL_W-1:0]  shift_type,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SEL_W-1:0]   aluout_sel,
    output logic               aluout_wr,
    output logic [SCTL_W-1:0]  shift_ctrl,
    output logic [SHAMT_W-1:0] shift_n
);

    state_e               state_q, state_d;
    logic [OP_W-1:0]      op_q;
    logic [SCTL_W-1:0]    st_q;
    logic [SHAMT_W-1:0]   shamt_q;
    logic                 start_alu_c;
    logic                 start_shift_c;
    logic                 accept_c;
    logic                 cnt_zero;

    assign start_alu_c   = start && is_alu_class(op_class);
    assign start_shift_c = start && (op_class == OP_SHIFT) && is_shift_type(shift_type);
    assign accept_c      = (state_q == ST_IDLE) && (start_alu_c || start_shift_c);

    aluout_exec_counter #(
        .EXEC_CYCLES (EXEC_CYCLES)
    ) u_exec_counter (
        .clk    (clk),
        .reset  (reset),
        .load_i (state_q == ST_SH_LOAD),
        .dec_i  (state_q == ST_SH_EXEC),
        .zero_o (cnt_zero)
    );

    // Operation latch: inputs are frozen for the whole operation once accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            st_q    <= '0;
            shamt_q <= '0;
        end else if (accept_c) begin
            op_q    <= op_class;
            st_q    <= shift_type;
            shamt_q <= shamt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_alu_c) begin
                    state_d = ST_WRITE;
                end else if (start_shift_c) begin
                    state_d = ST_SH_LOAD;
                end
            end
            ST_SH_LOAD: state_d = (shamt_q == '0) ? ST_WRITE : ST_SH_EXEC;
            ST_SH_EXEC: if (cnt_zero) state_d = ST_WRITE;
            ST_WRITE:   state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the registered state; err is the only input-dependent output.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        aluout_wr  = 1'b0;
        aluout_sel = '0;
        shift_ctrl = SC_NOP;
        shift_n    = '0;
        case (state_q)
            ST_SH_LOAD: begin
                busy       = 1'b1;
                aluout_sel = SEL_W'(op_q);
                shift_ctrl = SC_LOAD;
            end
            ST_SH_EXEC: begin
                busy       = 1'b1;
                aluout_sel = SEL_W'(op_q);
                shift_ctrl = st_q;
                shift_n    = shamt_q;
            end
            ST_WRITE: begin
                busy       = 1'b1;
                aluout_sel = SEL_W'(op_q);
                aluout_wr  = 1'b1;
            end
            ST_DONE: begin
                busy       = 1'b1;
                aluout_sel = SEL_W'(op_q);
                done       = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        err = (state_q == ST_IDLE) && start && !reset && !(start_alu_c || start_shift_c);
    end

endmodule

// File: tb/tb_aluout_sequencer.sv
// Scoreboard bench for aluout_sequencer: per-cycle expected outputs are queued when an
// op is driven and popped as the selected instance (EXEC_CYCLES 1 or 3) produces them.
module tb_aluout_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op_class;
    logic [2:0] shift_type;
    logic [4:0] shamt;

    logic       busy1, done1, err1, wr1;
    logic [2:0] sel1, sctl1;
    logic [4:0] sn1;
    logic       busy3, done3, err3, wr3;
    logic [2:0] sel3, sctl3;
    logic [4:0] sn3;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] sel;
        logic       wr;
        logic [2:0] sctl;
        logic [4:0] sn;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   sel_dut = 1;

    always #5 clk = ~clk;

    aluout_sequencer #(.SEL_W(3), .SHAMT_W(5), .EXEC_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .op_class(op_class),
        .shift_type(shift_type), .shamt(shamt), .busy(busy1), .done(done1),
        .err(err1), .aluout_sel(sel1), .aluout_wr(wr1), .shift_ctrl(sctl1), .shift_n(sn1)
    );

    aluout_sequencer #(.SEL_W(3), .SHAMT_W(5), .EXEC_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .op_class(op_class),
        .shift_type(shift_type), .shamt(shamt), .busy(busy3), .done(done3),
        .err(err3), .aluout_sel(sel3), .aluout_wr(wr3), .shift_ctrl(sctl3), .shift_n(sn3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic b, input logic d, input logic e, input logic [2:0] s,
                                input logic w, input logic [2:0] c, input logic [4:0] n);
        exp_t x;
        x.busy = b; x.done = d; x.err = e; x.sel = s; x.wr = w; x.sctl = c; x.sn = n;
        return x;
    endfunction

    task automatic cmp_cycle(input string tag);
        exp_t e, g;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        if (sel_dut == 1) g = mk(busy1, done1, err1, sel1, wr1, sctl1, sn1);
        else              g = mk(busy3, done3, err3, sel3, wr3, sctl3, sn3);
        check({tag, ".busy"}, 32'(g.busy), 32'(e.busy));
        check({tag, ".done"}, 32'(g.done), 32'(e.done));
        check({tag, ".err"},  32'(g.err),  32'(e.err));
        check({tag, ".sel"},  32'(g.sel),  32'(e.sel));
        check({tag, ".wr"},   32'(g.wr),   32'(e.wr));
        check({tag, ".sctl"}, 32'(g.sctl), 32'(e.sctl));
        check({tag, ".sn"},   32'(g.sn),   32'(e.sn));
    endtask

    // Expected per-cycle trace of one op, starting at the IDLE cycle that presents start.
    task automatic push_op(input logic [2:0] cls, input logic [2:0] st, input logic [4:0] sh);
        int  ex;
        bit  legal_alu, legal_sh;
        ex        = (sel_dut == 1) ? 1 : 3;
        legal_alu = (cls == 3'd0) || (cls == 3'd1) || (cls == 3'd3) || (cls == 3'd4);
        legal_sh  = (cls == 3'd2) && (st >= 3'd2) && (st <= 3'd6);
        if (!legal_alu && !legal_sh) begin
            sb_q.push_back(mk(0, 0, 1, 0, 0, 0, 0));
            sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            return;
        end
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        if (legal_sh) begin
            sb_q.push_back(mk(1, 0, 0, 3'd2, 0, 3'd1, 0));
            if (sh != 5'd0) begin
                for (int k = 0; k < ex; k++) sb_q.push_back(mk(1, 0, 0, 3'd2, 0, st, sh));
            end
        end
        sb_q.push_back(mk(1, 0, 0, cls, 1, 0, 0));
        sb_q.push_back(mk(1, 1, 0, cls, 0, 0, 0));
    endtask

    task automatic play_op(input logic [2:0] cls, input logic [2:0] st, input logic [4:0] sh,
                           input bit hold, input string tag);
        int n;
        push_op(cls, st, sh);
        n = sb_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b1; op_class = cls; shift_type = st; shamt = sh;
            end else begin
                start      = hold;
                op_class   = 3'($urandom_range(0, 7));
                shift_type = 3'($urandom_range(0, 7));
                shamt      = 5'($urandom_range(0, 31));
            end
            #2 cmp_cycle(tag);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #2;
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        cmp_cycle(tag);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op_class = '0; shift_type = '0; shamt = '0;
        repeat (3) @(negedge clk);
        #2;
        sel_dut = 1; sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); cmp_cycle("rst1");
        sel_dut = 3; sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); cmp_cycle("rst3");
        sel_dut = 1;
        do_reset("rst_rel");

        play_op(3'd1, 3'd0, 5'd0,  0, "alu");
        play_op(3'd2, 3'd3, 5'd4,  0, "srl4");
        play_op(3'd2, 3'd3, 5'd0,  0, "zshift");
        play_op(3'd6, 3'd2, 5'd3,  0, "ill_cls");
        play_op(3'd2, 3'd0, 5'd4,  0, "ill_st0");
        play_op(3'd2, 3'd7, 5'd1,  0, "ill_st7");
        play_op(3'd0, 3'd5, 5'd9,  0, "aux");
        play_op(3'd3, 3'd0, 5'd0,  0, "pass_a");
        play_op(3'd2, 3'd6, 5'd31, 0, "rol31");
        play_op(3'd2, 3'd2, 5'd1,  0, "sll1");
        for (int r = 0; r < 4; r++) play_op(3'd4, 3'd0, 5'd0, 1, "slt_hold");
        start = 1'b0;
        for (int r = 0; r < 12; r++)
            play_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 3)), 0, "rand");

        do_reset("rst_pre3");
        sel_dut = 3;
        play_op(3'd2, 3'd4, 5'd5, 0, "sra5_x3");
        play_op(3'd2, 3'd5, 5'd0, 0, "zshift_x3");
        play_op(3'd1, 3'd0, 5'd0, 0, "alu_x3");

        // Abort in SH_EXEC: reset sampled while the exec counter is still running.
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        sb_q.push_back(mk(1, 0, 0, 3'd2, 0, 3'd1, 0));
        sb_q.push_back(mk(1, 0, 0, 3'd2, 0, 3'd4, 5'd7));
        sb_q.push_back(mk(1, 0, 0, 3'd2, 0, 3'd4, 5'd7));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b1; op_class = 3'd2; shift_type = 3'd4; shamt = 5'd7;
            end else begin
                start = 1'b0;
            end
            if (i == 3) reset = 1'b1;
            #2 cmp_cycle("abort");
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            #2 cmp_cycle("post_abort");
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
